// File: rtl/mp64_rst_seq.sv
// mp64_rst_seq: staged reset release (mem -> periph -> cpu) gated on a
// synchronised PLL lock, with a saturating lock-loss event counter.
module mp64_rst_seq #(
  parameter int SYNC_STAGES = 2,
  parameter int LOCK_STABLE = 16,
  parameter int STAGE_GAP   = 8,
  parameter int CNT_W       = 8
) (
  input  logic             clk_in,
  input  logic             rst_in,
  input  logic             pll_locked,
  input  logic             sw_rst_req,
  input  logic             cnt_clr,
  output logic             rst_mem_out,
  output logic             rst_periph_out,
  output logic             rst_cpu_out,
  output logic             sys_ready,
  output logic [CNT_W-1:0] lock_loss_cnt
);

  localparam int TMAX =
    (LOCK_STABLE > STAGE_GAP) ? LOCK_STABLE : STAGE_GAP;
  localparam int TW = $clog2(TMAX + 1);

  typedef enum logic [2:0] {
    HOLD,
    STABLE,
    REL_MEM,
    REL_PERIPH,
    RUN
  } state_e;

  state_e state_q, state_d;

  logic [SYNC_STAGES-1:0] sync_q;
  logic [TW-1:0]          timer_q, timer_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic                   inc;
  logic                   locked_s;
  logic                   abort;

  logic mem_q, mem_d;
  logic per_q, per_d;
  logic cpu_q, cpu_d;
  logic rdy_q, rdy_d;

  assign locked_s = sync_q[SYNC_STAGES-1];
  assign abort    = !locked_s || sw_rst_req;

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      sync_q  <= '0;
      state_q <= HOLD;
      timer_q <= '0;
      cnt_q   <= '0;
      mem_q   <= 1'b1;
      per_q   <= 1'b1;
      cpu_q   <= 1'b1;
      rdy_q   <= 1'b0;
    end else begin
      sync_q  <= {sync_q[SYNC_STAGES-2:0], pll_locked};
      state_q <= state_d;
      timer_q <= timer_d;
      cnt_q   <= cnt_d;
      mem_q   <= mem_d;
      per_q   <= per_d;
      cpu_q   <= cpu_d;
      rdy_q   <= rdy_d;
    end
  end

  always_comb begin
    state_d = state_q;
    timer_d = timer_q;
    inc     = 1'b0;
    unique case (state_q)
      HOLD: begin
        timer_d = '0;
        if (locked_s) state_d = STABLE;
      end
      STABLE: begin
        if (abort) begin
          state_d = HOLD;
          timer_d = '0;
        end else if (timer_q == TW'(LOCK_STABLE - 1)) begin
          state_d = REL_MEM;
          timer_d = '0;
        end else begin
          timer_d = timer_q + 1'b1;
        end
      end
      REL_MEM, REL_PERIPH: begin
        if (abort) begin
          state_d = HOLD;
          timer_d = '0;
          inc     = !locked_s;
        end else if (timer_q == TW'(STAGE_GAP - 1)) begin
          state_d = (state_q == REL_MEM) ? REL_PERIPH : RUN;
          timer_d = '0;
        end else begin
          timer_d = timer_q + 1'b1;
        end
      end
      RUN: begin
        if (abort) begin
          state_d = HOLD;
          timer_d = '0;
          inc     = !locked_s;
        end
      end
      default: begin
        state_d = HOLD;
        timer_d = '0;
      end
    endcase
  end

  // Outputs are decoded from the next state so they land in flops.
  always_comb begin
    mem_d = (state_d == HOLD) || (state_d == STABLE);
    per_d = !((state_d == REL_PERIPH) || (state_d == RUN));
    cpu_d = (state_d != RUN);
    rdy_d = (state_d == RUN);
    if (cnt_clr)
      cnt_d = '0;
    else if (inc && (cnt_q != {CNT_W{1'b1}}))
      cnt_d = cnt_q + 1'b1;
    else
      cnt_d = cnt_q;
  end

  assign rst_mem_out    = mem_q;
  assign rst_periph_out = per_q;
  assign rst_cpu_out    = cpu_q;
  assign sys_ready      = rdy_q;
  assign lock_loss_cnt  = cnt_q;

endmodule

// File: tb/tb_mp64_rst_seq.sv
// tb_mp64_rst_seq: scoreboard bench; a progress-count model predicts
// every cycle's outputs, a negedge monitor pops and compares.
module tb_mp64_rst_seq;

  localparam int SS  = 2;
  localparam int LS  = 16;
  localparam int G   = 8;
  localparam int CW  = 8;
  localparam int MAX = (1 << CW) - 1;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic pll = 1'b0;
  logic sw  = 1'b0;
  logic clr = 1'b0;
  logic mem, per, cpu, rdy;
  logic [CW-1:0] cnt;

  mp64_rst_seq #(
    .SYNC_STAGES(SS),
    .LOCK_STABLE(LS),
    .STAGE_GAP  (G),
    .CNT_W      (CW)
  ) dut (
    .clk_in        (clk),
    .rst_in        (rst),
    .pll_locked    (pll),
    .sw_rst_req    (sw),
    .cnt_clr       (clr),
    .rst_mem_out   (mem),
    .rst_periph_out(per),
    .rst_cpu_out   (cpu),
    .sys_ready     (rdy),
    .lock_loss_cnt (cnt)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic          mem;
    logic          per;
    logic          cpu;
    logic          rdy;
    logic [CW-1:0] cnt;
  } exp_t;

  exp_t q[$];
  bit   hist[$];
  bit   m_active;
  int   m_p;
  int   m_cnt;
  int   errors = 0;
  int   checks = 0;

  // Model: m_p counts edges since the lock was first seen in a
  // quiescent state; release points are fixed offsets of it.
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      q.delete();
      hist.delete();
      for (int i = 0; i < SS; i++) hist.push_back(1'b0);
      m_active = 1'b0;
      m_p      = 0;
      m_cnt    = 0;
    end else begin : step
      bit   ls;
      bit   inc;
      exp_t e;
      inc = 1'b0;
      ls  = hist.pop_front();
      hist.push_back(pll);
      if (m_active && (!ls || sw)) begin
        inc      = !ls && (m_p >= LS);
        m_active = 1'b0;
      end else if (!m_active && ls) begin
        m_active = 1'b1;
        m_p      = 0;
      end else if (m_active && m_p < LS + 2 * G) begin
        m_p++;
      end
      if (clr) m_cnt = 0;
      else if (inc && m_cnt < MAX) m_cnt++;
      e.mem = !(m_active && m_p >= LS);
      e.per = !(m_active && m_p >= LS + G);
      e.cpu = !(m_active && m_p >= LS + 2 * G);
      e.rdy = !e.cpu;
      e.cnt = CW'(m_cnt);
      q.push_back(e);
    end
  end

  always @(negedge clk) begin : mon
    exp_t a;
    exp_t e;
    bit   have;
    a    = {mem, per, cpu, rdy, cnt};
    have = 1'b0;
    if (rst) begin
      e    = {1'b1, 1'b1, 1'b1, 1'b0, {CW{1'b0}}};
      have = 1'b1;
    end else if (q.size() > 0) begin
      e    = q.pop_front();
      have = 1'b1;
    end
    if (have) begin
      checks++;
      if (a !== e) begin
        errors++;
        $display("FAIL outputs t=%0t got mem=%b per=%b cpu=%b rdy=%b cnt=%0d want mem=%b per=%b cpu=%b rdy=%b cnt=%0d",
                 $time, a.mem, a.per, a.cpu, a.rdy, a.cnt,
                 e.mem, e.per, e.cpu, e.rdy, e.cnt);
      end
    end
    checks++;
    if ((!per && mem) || (!cpu && per) || (rdy !== !cpu)) begin
      errors++;
      $display("FAIL order t=%0t got mem=%b per=%b cpu=%b rdy=%b want downstream never ahead",
               $time, mem, per, cpu, rdy);
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  task automatic pulse_sw();
    sw = 1'b1;
    tick(1);
    sw = 1'b0;
  endtask

  initial begin
    pll = 1'b1;
    #1 rst = 1'b1;
    tick(3);
    rst = 1'b0;
    tick(40);
    // lock loss in RUN, then re-lock
    pll = 1'b0;
    tick(5);
    pll = 1'b1;
    tick(40);
    // soft reset in RUN
    pulse_sw();
    tick(40);
    // short lock glitch while waiting for stability
    pll = 1'b0;
    tick(6);
    pll = 1'b1;
    tick(12);
    pll = 1'b0;
    tick(3);
    pll = 1'b1;
    tick(40);
    // drive the counter into saturation
    repeat (MAX + 5) begin
      pll = 1'b1;
      tick(22);
      pll = 1'b0;
      tick(4);
    end
    // clear lands on the same edge as a counted lock loss
    pll = 1'b1;
    tick(30);
    pll = 1'b0;
    tick(2);
    clr = 1'b1;
    tick(1);
    clr = 1'b0;
    tick(5);
    // asynchronous reset while peripherals are being released
    pll = 1'b1;
    tick(30);
    rst = 1'b1;
    tick(2);
    rst = 1'b0;
    tick(40);
    // random mix
    repeat (60) begin
      pll = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 7) == 0) pulse_sw();
      if ($urandom_range(0, 15) == 0) begin
        clr = 1'b1;
        tick(1);
        clr = 1'b0;
      end
      tick($urandom_range(1, 40));
    end
    pll = 1'b1;
    tick(40);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/mp64_rst_seq.md
Name: mp64_rst_seq

Overview:
Reset sequencer that consumes the PLL lock indicator and turns it into staged, synchronously released resets for the system clock domain. Order of release is memory, then peripherals, then CPU, which raises sys_ready. Lock loss or a software reset request re-asserts all resets and restarts the sequence. It also keeps a saturating count of lock-loss events for diagnostics.

Parameters:
SYNC_STAGES, 2, synchroniser flops on pll_locked (min 2)
LOCK_STABLE, 16, cycles locked_s must stay high before memory reset release (min 1)
STAGE_GAP, 8, cycles between successive stage releases (min 1)
CNT_W, 8, width of lock-loss counter

Ports:
clk_in  in  1  system clock (generated clock domain)
rst_in  in  1  reset, asynchronous, active-high
pll_locked  in  1  PLL lock indicator, asynchronous to clk_in
sw_rst_req  in  1  synchronous single-cycle soft reset request
cnt_clr  in  1  synchronous clear of lock_loss_cnt
rst_mem_out  out  1  memory-subsystem reset, active-high
rst_periph_out  out  1  peripheral reset, active-high
rst_cpu_out  out  1  CPU reset, active-high
sys_ready  out  1  high when all stages are released
lock_loss_cnt  out  CNT_W  saturating lock-loss event count

Behaviour:
- Clock clk_in. Reset rst_in is asynchronous and active-high. All flops reset asynchronously.
- Reset values: rst_mem_out = rst_periph_out = rst_cpu_out = 1, sys_ready = 0, lock_loss_cnt = 0, state HOLD, timer 0, synchroniser flops 0.
- All outputs are registered. No combinational path from any input to any output.
- locked_s is pll_locked after a SYNC_STAGES flop chain.
- States: HOLD, STABLE, REL_MEM, REL_PERIPH, RUN.
  - HOLD: timer = 0, all resets high. If locked_s, go to STABLE.
  - STABLE: if !locked_s, go to HOLD with no count increment. Otherwise timer++. When timer == LOCK_STABLE-1, go to REL_MEM with timer = 0 and rst_mem_out = 0.
  - REL_MEM: timer++. When timer == STAGE_GAP-1, go to REL_PERIPH with timer = 0 and rst_periph_out = 0.
  - REL_PERIPH: timer++. When timer == STAGE_GAP-1, go to RUN with rst_cpu_out = 0 and sys_ready = 1.
  - RUN: hold until an abort occurs.
- Abort, in REL_MEM, REL_PERIPH or RUN only:
  - Triggered by !locked_s or sw_rst_req.
  - Next edge: state HOLD, all three resets = 1, sys_ready = 0, timer = 0.
  - lock_loss_cnt increments only if !locked_s. This includes the case where !locked_s and sw_rst_req occur in the same cycle.
- sw_rst_req in HOLD or STABLE: STABLE goes to HOLD and timer restarts. HOLD is unaffected.
- Counter:
  - Saturates at 2^CNT_W-1.
  - cnt_clr has priority over an increment in the same cycle; the result is 0.
- Timing, where pll_locked rises before edge k with defaults:
  - rst_mem_out low after edge k+SYNC_STAGES+LOCK_STABLE (k+18).
  - rst_periph_out low after edge k+26.
  - rst_cpu_out low and sys_ready high after edge k+34.
- Lock-loss latency: pll_locked falls before edge m, so all resets are high after edge m+SYNC_STAGES.
- Release order is strict. A downstream reset is never low while an upstream reset is high.
- rst_in mid-sequence: every output returns to its reset value immediately, without waiting for a clock edge, and lock_loss_cnt is cleared.

Test Plan:
- Reset defaults: assert rst_in with pll_locked = 1 → all resets 1, sys_ready 0, cnt 0. Deassert rst_in → standard release at k+18/k+26/k+34.
- Nominal release: pll_locked rises before edge 0 → rst_mem_out 1→0 after edge 18, rst_periph_out after edge 26, rst_cpu_out and sys_ready after edge 34. Ordering assertion holds throughout.
- Lock glitch in STABLE: locked_s drops for 3 cycles at timer = 10 → return to HOLD, cnt stays 0, full LOCK_STABLE wait from the re-lock.
- Lock loss in RUN: pll_locked falls before edge m → all resets 1 and sys_ready 0 after edge m+2, cnt = 1. Re-lock → full sequence repeats.
- sw_rst_req pulse in RUN → resets 1 next edge, cnt unchanged, sequence restarts since pll_locked is still high.
- Counter edge cases:
  - Force 255 lock losses → cnt saturates at 255.
  - Lock loss and cnt_clr in the same cycle → cnt = 0.
  - rst_in pulse mid-REL_PERIPH → all outputs reset asynchronously.
